// File: rtl/symbol_packer_pkg.sv
// Shared types and constants for the symbol packer RX stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package symbol_packer_pkg;

    // Modulation mode encodings used across the RX chain.
    typedef enum logic [1:0] {
        MODE_BPSK = 2'd0,
        MODE_QPSK = 2'd1,
        MODE_MIX  = 2'd2
    } mode_e;

    // Symbol bits are packed so the first received bit lands in bit 7.
    localparam bit AXIS_MSB_FIRST = 1'b1;

    localparam logic [3:0] BYTE_BITS = 4'd8;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_TAIL = 1'b1
    } state_e;

    // Number of bits carried by one input beat: BPSK 1, QPSK 2.
    function automatic logic [3:0] sym_bits(input logic bpsk);
        return bpsk ? 4'd1 : 4'd2;
    endfunction

endpackage

// File: rtl/symbol_packer_if.sv
// Stream bundle for symbol_packer: symbol input, packed byte output, frame status.
// Latency: n/a (wiring only).
// Backpressure: s_tready/m_tready carry AXIS valid-ready flow control.
// Ports: s_* = symbol stream from depacketizer, m_* = byte stream to DMA,
//        byte_cnt/frame_done = per-frame status from the packer.
interface symbol_packer_if #(
    parameter int IN_BYTES  = 1,
    parameter int CNT_WIDTH = 16
);
    logic [IN_BYTES*8-1:0]  s_tdata;
    logic                   s_tvalid;
    logic                   s_tready;
    logic                   s_tlast;
    logic                   s_tuser;

    logic [7:0]             m_tdata;
    logic                   m_tvalid;
    logic                   m_tready;
    logic                   m_tlast;
    logic [2:0]             m_pad;

    logic [CNT_WIDTH-1:0]   byte_cnt;
    logic                   frame_done;

    // Packer side.
    modport slave (
        input  s_tdata, s_tvalid, s_tlast, s_tuser, m_tready,
        output s_tready, m_tdata, m_tvalid, m_tlast, m_pad, byte_cnt, frame_done
    );

    // Environment side (upstream source + downstream sink).
    modport master (
        output s_tdata, s_tvalid, s_tlast, s_tuser, m_tready,
        input  s_tready, m_tdata, m_tvalid, m_tlast, m_pad, byte_cnt, frame_done
    );

endinterface

// File: rtl/symbol_packer_axis_out_reg.sv
// Output register for the packed byte stream (data + last + pad) with AXIS hold.
// Latency: 1 cycle from load_i to vld_o.
// Backpressure: holds contents while vld_o & ~rdy_i; free_o allows reload on handshake.
// Ports: load_i/dat_i/last_i/pad_i = new byte, rdy_i = downstream ready,
//        vld_o/dat_o/last_o/pad_o = registered byte, free_o = may load this cycle.
module symbol_packer_axis_out_reg (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic [7:0] dat_i,
    input  logic       last_i,
    input  logic [2:0] pad_i,
    input  logic       rdy_i,
    output logic       vld_o,
    output logic [7:0] dat_o,
    output logic       last_o,
    output logic [2:0] pad_o,
    output logic       free_o
);

    logic       vld_q,  vld_d;
    logic [7:0] dat_q,  dat_d;
    logic       last_q, last_d;
    logic [2:0] pad_q,  pad_d;

    // Register is free when empty or when its byte leaves this cycle.
    assign free_o = ~vld_q | rdy_i;

    always_comb begin
        vld_d  = vld_q;
        dat_d  = dat_q;
        last_d = last_q;
        pad_d  = pad_q;
        if (load_i) begin
            // A load in the handshake cycle replaces the departing byte.
            vld_d  = 1'b1;
            dat_d  = dat_i;
            last_d = last_i;
            pad_d  = pad_i;
        end else if (vld_q && rdy_i) begin
            vld_d  = 1'b0;
            last_d = 1'b0;
            pad_d  = 3'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= 1'b0;
            dat_q  <= 8'd0;
            last_q <= 1'b0;
            pad_q  <= 3'd0;
        end else begin
            vld_q  <= vld_d;
            dat_q  <= dat_d;
            last_q <= last_d;
            pad_q  <= pad_d;
        end
    end

    assign vld_o  = vld_q;
    assign dat_o  = dat_q;
    assign last_o = last_q;
    assign pad_o  = pad_q;

endmodule

// File: rtl/symbol_packer.sv
// Packs BPSK/QPSK symbols (1 or 2 bits per beat) MSB-first into bytes with frame pad/count.
// Latency: 1 cycle from the completing input beat to m_tvalid.
// Backpressure: s_tready = RUN & output register free; TAIL blocks input for one extra byte.
// Ports: clk, rst (sync, active-high); bus = symbol_packer_if.slave carrying
//        s_* input stream, m_* byte stream, byte_cnt and frame_done.
module symbol_packer
    import symbol_packer_pkg::*;
#(
    parameter int IN_BYTES  = 1,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    symbol_packer_if.slave       bus
);

    state_e               state_q, state_d;
    logic [7:0]           acc_q,   acc_d;
    logic [3:0]           fill_q,  fill_d;
    logic [CNT_WIDTH-1:0] cnt_q,   cnt_d;
    logic                 done_q,  done_d;

    logic                 out_free;
    logic                 out_vld;
    logic                 out_last;
    logic                 load;
    logic [7:0]           ld_dat;
    logic                 ld_last;
    logic [2:0]           ld_pad;

    logic                 accept;
    logic [1:0]           sym;
    logic [8:0]           merged;
    logic [3:0]           new_fill;
    logic                 last_hs;
    logic [CNT_WIDTH-1:0] cnt_base;

    // Only s_tdata[1:0] carries the symbol.
    logic unused_upper;
    assign unused_upper = ^bus.s_tdata[IN_BYTES*8-1:2];

    assign bus.s_tready = (state_q == ST_RUN) && out_free;
    assign accept       = bus.s_tvalid && bus.s_tready;

    // BPSK uses s_tdata[1] only; left-align so both modes insert from the top.
    assign sym      = bus.s_tuser ? {bus.s_tdata[1], 1'b0} : bus.s_tdata[1:0];
    // 9-bit window: byte in [8:1], possible QPSK overflow bit in [0].
    assign merged   = {acc_q, 1'b0} | ({sym, 7'b0} >> fill_q);
    assign new_fill = fill_q + sym_bits(bus.s_tuser);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        fill_d  = fill_q;
        load    = 1'b0;
        ld_dat  = merged[8:1];
        ld_last = 1'b0;
        ld_pad  = 3'd0;
        case (state_q)
            ST_RUN: begin
                if (accept) begin
                    if (new_fill == 4'd9) begin
                        // Full byte out now; the spill bit waits in acc[7].
                        load   = 1'b1;
                        acc_d  = {merged[0], 7'b0};
                        fill_d = 4'd1;
                        if (bus.s_tlast) begin
                            state_d = ST_TAIL;
                        end
                    end else if (bus.s_tlast) begin
                        load    = 1'b1;
                        ld_last = 1'b1;
                        ld_pad  = 3'(BYTE_BITS - new_fill);
                        acc_d   = 8'd0;
                        fill_d  = 4'd0;
                    end else if (new_fill == BYTE_BITS) begin
                        load   = 1'b1;
                        acc_d  = 8'd0;
                        fill_d = 4'd0;
                    end else begin
                        acc_d  = merged[8:1];
                        fill_d = new_fill;
                    end
                end
            end
            ST_TAIL: begin
                // Flush the single spill bit once the full byte has left.
                if (out_free) begin
                    load    = 1'b1;
                    ld_dat  = {acc_q[7], 7'b0};
                    ld_last = 1'b1;
                    ld_pad  = 3'd7;
                    acc_d   = 8'd0;
                    fill_d  = 4'd0;
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Frame end clears the count, so a byte loaded in the same cycle counts as 1.
    assign last_hs  = out_vld && bus.m_tready && out_last;
    assign cnt_base = last_hs ? '0 : cnt_q;

    always_comb begin
        cnt_d = cnt_base;
        if (load && (cnt_base != '1)) begin
            cnt_d = cnt_base + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
        done_d = last_hs;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            acc_q   <= 8'd0;
            fill_q  <= 4'd0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    symbol_packer_axis_out_reg u_out (
        .clk    (clk),
        .rst    (rst),
        .load_i (load),
        .dat_i  (ld_dat),
        .last_i (ld_last),
        .pad_i  (ld_pad),
        .rdy_i  (bus.m_tready),
        .vld_o  (out_vld),
        .dat_o  (bus.m_tdata),
        .last_o (out_last),
        .pad_o  (bus.m_pad),
        .free_o (out_free)
    );

    assign bus.m_tvalid   = out_vld;
    assign bus.m_tlast    = out_last;
    assign bus.byte_cnt   = cnt_q;
    assign bus.frame_done = done_q;

endmodule

// File: tb/tb_symbol_packer.sv
// Directed bench for symbol_packer: hand-computed byte streams, stall and reset cases.
// Latency: n/a.
// Backpressure: m_tready driven per test (always, toggling, never).
module tb_symbol_packer;

    typedef struct {
        logic [1:0] d;
        logic       u;
        logic       l;
    } beat_t;

    typedef struct {
        logic [7:0]  d;
        logic        l;
        logic [2:0]  p;
        logic [15:0] c;
    } obyte_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    symbol_packer_if #(.IN_BYTES(1), .CNT_WIDTH(16)) bus ();

    symbol_packer #(.IN_BYTES(1), .CNT_WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int tail_chk = 0;

    beat_t  in_q[$];
    obyte_t exp_q[$];
    obyte_t out_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic add(input logic [1:0] d, input logic u, input logic l);
        beat_t b;
        b.d = d; b.u = u; b.l = l;
        in_q.push_back(b);
    endtask

    task automatic expb(input logic [7:0] d, input logic l, input logic [2:0] p, input logic [15:0] c);
        obyte_t o;
        o.d = d; o.l = l; o.p = p; o.c = c;
        exp_q.push_back(o);
    endtask

    // rdy_mode: 0 = always ready, 1 = toggle each cycle, 2 = never ready.
    task automatic run(input string name, input int rdy_mode, input int exp_fd);
        int     cyc = 0;
        int     idle = 0;
        int     fd = 0;
        logic   prev_stall = 1'b0;
        logic [7:0] prev_dat = 8'd0;
        obyte_t o;
        out_q.delete();
        while (cyc < 300 && !(in_q.size() == 0 && out_q.size() == exp_q.size() && idle >= 3)) begin
            if (in_q.size() > 0) begin
                bus.s_tvalid = 1'b1;
                bus.s_tdata  = {6'b101010, in_q[0].d};
                bus.s_tuser  = in_q[0].u;
                bus.s_tlast  = in_q[0].l;
            end else begin
                bus.s_tvalid = 1'b0;
                bus.s_tdata  = 8'd0;
                bus.s_tuser  = 1'b0;
                bus.s_tlast  = 1'b0;
            end
            bus.m_tready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? ((cyc % 2) == 0) : 1'b0;
            #1;
            if (bus.frame_done) fd++;
            if (prev_stall) begin
                chk({name, "_stall_vld"}, 32'(bus.m_tvalid), 32'd1);
                chk({name, "_stall_dat"}, 32'(bus.m_tdata), 32'(prev_dat));
            end
            if (rdy_mode == 1)
                chk({name, "_s_tready"}, 32'(bus.s_tready), 32'(!(bus.m_tvalid && !bus.m_tready)));
            if (tail_chk != 0 && bus.m_tvalid && !bus.m_tlast)
                chk({name, "_tail_rdy"}, 32'(bus.s_tready), 32'd0);
            if (bus.m_tvalid && bus.m_tready) begin
                o.d = bus.m_tdata; o.l = bus.m_tlast; o.p = bus.m_pad; o.c = bus.byte_cnt;
                out_q.push_back(o);
            end
            if (bus.s_tvalid && bus.s_tready) void'(in_q.pop_front());
            prev_stall = bus.m_tvalid && !bus.m_tready;
            prev_dat   = bus.m_tdata;
            if (in_q.size() == 0 && out_q.size() == exp_q.size()) idle++;
            cyc++;
            @(negedge clk);
        end
        chk({name, "_in_budget"}, 32'(cyc < 300), 32'd1);
        chk({name, "_nbytes"}, 32'(out_q.size()), 32'(exp_q.size()));
        foreach (exp_q[i]) begin
            if (i < out_q.size()) begin
                chk($sformatf("%s_b%0d_dat", name, i),  32'(out_q[i].d), 32'(exp_q[i].d));
                chk($sformatf("%s_b%0d_last", name, i), 32'(out_q[i].l), 32'(exp_q[i].l));
                chk($sformatf("%s_b%0d_pad", name, i),  32'(out_q[i].p), 32'(exp_q[i].p));
                chk($sformatf("%s_b%0d_cnt", name, i),  32'(out_q[i].c), 32'(exp_q[i].c));
            end
        end
        chk({name, "_frame_done"}, 32'(fd), 32'(exp_fd));
        if (exp_fd > 0) chk({name, "_cnt_clr"}, 32'(bus.byte_cnt), 32'd0);
        in_q.delete();
        exp_q.delete();
        bus.s_tvalid = 1'b0;
        bus.m_tready = 1'b1;
    endtask

    task automatic check_zero(input string name);
        chk({name, "_vld"},  32'(bus.m_tvalid),   32'd0);
        chk({name, "_dat"},  32'(bus.m_tdata),    32'd0);
        chk({name, "_last"}, 32'(bus.m_tlast),    32'd0);
        chk({name, "_pad"},  32'(bus.m_pad),      32'd0);
        chk({name, "_cnt"},  32'(bus.byte_cnt),   32'd0);
        chk({name, "_done"}, 32'(bus.frame_done), 32'd0);
        chk({name, "_srdy"}, 32'(bus.s_tready),   32'd1);
    endtask

    task automatic do_reset();
        bus.s_tvalid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        #1;
        check_zero("rst");
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        bus.s_tdata  = 8'd0;
        bus.s_tvalid = 1'b0;
        bus.s_tlast  = 1'b0;
        bus.s_tuser  = 1'b0;
        bus.m_tready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_zero("init");
        rst = 1'b0;
        @(negedge clk);

        // 1: QPSK 11,00,10,01 -> 0xC9
        add(2'b11, 1'b0, 1'b0); add(2'b00, 1'b0, 1'b0);
        add(2'b10, 1'b0, 1'b0); add(2'b01, 1'b0, 1'b1);
        expb(8'hC9, 1'b1, 3'd0, 16'd1);
        run("t1", 0, 1);

        // 2: BPSK 1,0,1,1,0,0,0,1 then 8 x QPSK 10 -> B1 AA AA
        add(2'b10, 1'b1, 1'b0); add(2'b00, 1'b1, 1'b0);
        add(2'b10, 1'b1, 1'b0); add(2'b10, 1'b1, 1'b0);
        add(2'b00, 1'b1, 1'b0); add(2'b00, 1'b1, 1'b0);
        add(2'b00, 1'b1, 1'b0); add(2'b10, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) add(2'b10, 1'b0, (i == 7));
        expb(8'hB1, 1'b0, 3'd0, 16'd1);
        expb(8'hAA, 1'b0, 3'd0, 16'd2);
        expb(8'hAA, 1'b1, 3'd0, 16'd3);
        run("t2", 0, 1);

        // 3: 7 BPSK ones + QPSK 01 last -> FE then 80 (pad 7), TAIL holds input
        for (int i = 0; i < 7; i++) add(2'b10, 1'b1, 1'b0);
        add(2'b01, 1'b0, 1'b1);
        expb(8'hFE, 1'b0, 3'd0, 16'd1);
        expb(8'h80, 1'b1, 3'd7, 16'd2);
        tail_chk = 1;
        run("t3", 0, 1);
        tail_chk = 0;

        // 4: BPSK 1,1,0 last -> C0 pad 5
        add(2'b10, 1'b1, 1'b0); add(2'b10, 1'b1, 1'b0); add(2'b00, 1'b1, 1'b1);
        expb(8'hC0, 1'b1, 3'd5, 16'd1);
        run("t4", 0, 1);

        // 5: QPSK stream with toggling m_tready -> 1B E4 96 3C
        add(2'b00, 1'b0, 1'b0); add(2'b01, 1'b0, 1'b0); add(2'b10, 1'b0, 1'b0); add(2'b11, 1'b0, 1'b0);
        add(2'b11, 1'b0, 1'b0); add(2'b10, 1'b0, 1'b0); add(2'b01, 1'b0, 1'b0); add(2'b00, 1'b0, 1'b0);
        add(2'b10, 1'b0, 1'b0); add(2'b01, 1'b0, 1'b0); add(2'b01, 1'b0, 1'b0); add(2'b10, 1'b0, 1'b0);
        add(2'b00, 1'b0, 1'b0); add(2'b11, 1'b0, 1'b0); add(2'b11, 1'b0, 1'b0); add(2'b00, 1'b0, 1'b1);
        expb(8'h1B, 1'b0, 3'd0, 16'd1);
        expb(8'hE4, 1'b0, 3'd0, 16'd2);
        expb(8'h96, 1'b0, 3'd0, 16'd3);
        expb(8'h3C, 1'b1, 3'd0, 16'd4);
        run("t5", 1, 1);

        // 6a: byte stalled at the output, then reset clears it
        for (int i = 0; i < 4; i++) add(2'b11, 1'b0, (i == 3));
        run("t6a", 2, 0);
        chk("t6a_pre_vld", 32'(bus.m_tvalid), 32'd1);
        chk("t6a_pre_dat", 32'(bus.m_tdata), 32'hFF);
        chk("t6a_pre_cnt", 32'(bus.byte_cnt), 32'd1);
        do_reset();

        // 6b: reset after 5 bits, next frame packs from bit 0
        for (int i = 0; i < 5; i++) add(2'b10, 1'b1, 1'b0);
        run("t6b", 0, 0);
        do_reset();
        for (int i = 0; i < 4; i++) add(2'b01, 1'b0, (i == 3));
        expb(8'h55, 1'b1, 3'd0, 16'd1);
        run("t6c", 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
